// File: rtl/px_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : px_spi_pkg
// Brief   : Shared state encoding and mode-bit indices for the px_spi engine.
// Revision: 1.0
// ============================================================================
package px_spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam int c_CPOL_BIT = 1;
   localparam int c_CPHA_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/px_spi_clkdiv.sv
`default_nettype none
// ============================================================================
// Module  : px_spi_clkdiv
// Brief   : One-cycle tick every 2**div_clk clk cycles while enabled.
// Revision: 1.0
// ============================================================================
module px_spi_clkdiv
   import px_spi_pkg::*;
#(
   parameter int DIV_MAX = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] div_clk,
   input  logic       enable,
   output logic       tick
);

   localparam int c_CNT_W = (DIV_MAX > 0) ? DIV_MAX : 1;

   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_last;
   logic [1:0]         w_div;

   // Out-of-range codes saturate to the slowest legal rate.
   always_comb begin
      w_div  = (int'(div_clk) > DIV_MAX) ? 2'(DIV_MAX) : div_clk;
      w_last = c_CNT_W'((32'd1 << w_div) - 32'd1);
   end

   assign tick = enable && (r_cnt == w_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!enable || (r_cnt == w_last)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/px_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module  : px_spi_shifter
// Brief   : SPI master serial engine (SETUP/SHIFT/HOLD), modes 0-3, div 1..8.
//           Optional LSB-first support when PX_SPI_LSB_FIRST_EN is defined.
// Revision: 1.0
// ============================================================================
module px_spi_shifter
   import px_spi_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int DIV_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_t,
   input  logic [1:0]        mode,
   input  logic [1:0]        div_clk,
`ifdef PX_SPI_LSB_FIRST_EN
   input  logic              lsb_first,
`endif
   input  logic              miso,
   output logic              sclk,
   output logic              mosi,
   output logic              cs_n,
   output logic [DATA_W-1:0] data_r,
   output logic              busy,
   output logic              done
);

   localparam int c_EDGE_W = $clog2(2*DATA_W) + 1;
   localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(2*DATA_W - 1);

   state_t              r_state;
   logic                r_cpol, r_cpha, r_lsb;
   logic [1:0]          r_div;
   logic [c_EDGE_W-1:0] r_edge;
   logic [DATA_W-1:0]   r_tx, r_rx, r_data_r;
   logic                r_sclk, r_mosi, r_cs_n, r_busy, r_done;
   logic                w_tick, w_lsb_in, w_sample;

`ifdef PX_SPI_LSB_FIRST_EN
   assign w_lsb_in = lsb_first;
`else
   assign w_lsb_in = 1'b0;
`endif

   function automatic logic front(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
   endfunction

   px_spi_clkdiv #(.DIV_MAX(DIV_MAX)) u_clkdiv (
      .clk     (clk),
      .rst     (rst),
      .div_clk (r_div),
      .enable  (r_state != ST_IDLE),
      .tick    (w_tick)
   );

   // Even edge counts are leading edges; CPHA selects sample vs. drive on them.
   assign w_sample = (~r_edge[0]) ^ r_cpha;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cpol   <= 1'b0;
         r_cpha   <= 1'b0;
         r_lsb    <= 1'b0;
         r_div    <= 2'd0;
         r_edge   <= '0;
         r_tx     <= '0;
         r_rx     <= '0;
         r_data_r <= '0;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b0;
         r_cs_n   <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cpol <= mode[c_CPOL_BIT];
                  r_cpha <= mode[c_CPHA_BIT];
                  r_div  <= div_clk;
                  r_lsb  <= w_lsb_in;
                  r_sclk <= mode[c_CPOL_BIT];
                  r_cs_n <= 1'b0;
                  r_busy <= 1'b1;
                  r_edge <= '0;
                  r_rx   <= '0;
                  if (mode[c_CPHA_BIT]) begin
                     r_mosi <= 1'b0;
                     r_tx   <= data_t;
                  end else begin
                     r_mosi <= front(data_t, w_lsb_in);
                     r_tx   <= advance(data_t, w_lsb_in);
                  end
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_tick) r_state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (w_tick) begin
                  r_sclk <= ~r_sclk;
                  if (w_sample) begin
                     r_rx <= r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
                  end else begin
                     r_mosi <= front(r_tx, r_lsb);
                     r_tx   <= advance(r_tx, r_lsb);
                  end
                  if (r_edge == c_LAST_EDGE) begin
                     r_edge  <= '0;
                     r_state <= ST_HOLD;
                  end else begin
                     r_edge <= r_edge + c_EDGE_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (w_tick) begin
                  r_state  <= ST_IDLE;
                  r_cs_n   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_mosi   <= 1'b0;
                  r_data_r <= r_rx;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign sclk   = r_sclk;
   assign mosi   = r_mosi;
   assign cs_n   = r_cs_n;
   assign data_r = r_data_r;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_px_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module  : tb_px_spi_shifter
// Brief   : Scoreboard bench for px_spi_shifter with an SPI slave model.
//           Exercises LSB-first transfers when PX_SPI_LSB_FIRST_EN is defined.
// Revision: 1.0
// ============================================================================
module tb_px_spi_shifter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] data_t = 8'h00;
   logic [1:0] mode = 2'd0;
   logic [1:0] div_clk = 2'd0;
`ifdef PX_SPI_LSB_FIRST_EN
   logic       lsb_first = 1'b0;
`endif
   logic       miso;
   logic       sclk, mosi, cs_n, busy, done;
   logic [7:0] data_r;

   px_spi_shifter #(.DATA_W(8), .DIV_MAX(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data_t    (data_t),
      .mode      (mode),
      .div_clk   (div_clk),
`ifdef PX_SPI_LSB_FIRST_EN
      .lsb_first (lsb_first),
`endif
      .miso      (miso),
      .sclk      (sclk),
      .mosi      (mosi),
      .cs_n      (cs_n),
      .data_r    (data_r),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] rx;
      logic [7:0] resp;
      logic [1:0] mode;
      int         h;
      bit         lp;
      bit         lsb;
      int         start_cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic bit_at(input logic [7:0] v, input bit lsb, input int k);
      return lsb ? v[k] : v[7-k];
   endfunction

   // SPI slave model and done monitor
   logic       p_sclk = 1'b0, p_cs_n = 1'b1, miso_drv = 1'b0;
   bit         s_loop = 1'b0, s_lsb = 1'b0;
   logic [1:0] s_mode = 2'd0;
   logic [7:0] s_resp = 8'h00, s_rx = 8'h00;
   int         s_rx_idx = 0, s_tx_idx = 0, s_rise = 0;

   assign miso = s_loop ? mosi : miso_drv;

   always @(negedge clk) begin
      exp_t e;
      if (p_cs_n && !cs_n) begin
         if (q.size() > 0) begin
            s_mode = q[0].mode;
            s_lsb  = q[0].lsb;
            s_resp = q[0].resp;
            s_loop = q[0].lp;
         end
         s_rx = 8'h00; s_rx_idx = 0; s_rise = 0;
         if (!s_mode[0]) begin
            miso_drv = bit_at(s_resp, s_lsb, 0);
            s_tx_idx = 1;
         end else begin
            s_tx_idx = 0;
         end
      end else if (!p_cs_n && !cs_n && (sclk != p_sclk)) begin
         if (sclk) s_rise++;
         if ((sclk != s_mode[1]) ^ s_mode[0]) begin
            if (s_rx_idx < 8) s_rx[s_lsb ? s_rx_idx : 7 - s_rx_idx] = mosi;
            s_rx_idx++;
         end else begin
            if (s_tx_idx < 8) miso_drv = bit_at(s_resp, s_lsb, s_tx_idx);
            s_tx_idx++;
         end
      end
      if (done && !rst) begin
         chk("done_expected", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("latency",    cyc - e.start_cyc, 18 * e.h + 1);
            chk("data_r",     data_r, e.rx);
            chk("mosi_bits",  s_rx, e.tx);
            chk("sclk_rises", s_rise, 8);
            chk("sclk_idle",  sclk, e.mode[1]);
            chk("cs_n_done",  cs_n, 1);
            chk("busy_done",  busy, 0);
            chk("mosi_done",  mosi, 0);
         end
      end
      p_sclk = sclk;
      p_cs_n = cs_n;
   end

   task automatic randomize_inputs();
      data_t  = 8'($urandom);
      mode    = 2'($urandom);
      div_clk = 2'($urandom);
`ifdef PX_SPI_LSB_FIRST_EN
      lsb_first = 1'($urandom);
`endif
   endtask

   // Issues a start at the current negedge; returns at the negedge of the done cycle.
   task automatic xfer(input logic [7:0] d, input logic [1:0] m, input logic [1:0] dv,
                       input logic [7:0] resp, input bit lp, input bit lsb, input int spur_at);
      exp_t e;
      int   n;
      bit   got;
      data_t = d; mode = m; div_clk = dv;
`ifdef PX_SPI_LSB_FIRST_EN
      lsb_first = lsb;
`endif
      start = 1'b1;
      e.tx = d; e.resp = resp; e.rx = lp ? d : resp; e.mode = m;
      e.h = 1 << dv; e.lp = lp; e.lsb = lsb; e.start_cyc = cyc;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      randomize_inputs();
      chk("cs_n_low", cs_n, 0);
      chk("busy_high", busy, 1);
      if (!m[0]) chk("first_mosi", mosi, lsb ? d[0] : d[7]);
      n = 1; got = 0;
      while (!got && n <= 400) begin
         if (done) begin
            got = 1;
         end else begin
            if (n == spur_at || $urandom_range(0, 15) == 0) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            randomize_inputs();
            n++;
         end
      end
      if (!got) begin
         chk("done_timeout", 0, 1);
         q.delete();
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bit lsb;
      @(negedge clk);
      @(negedge clk);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_data_r", data_r, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      idle(2);

      xfer(8'hA5, 2'd0, 2'd0, 8'h00, 1, 0, -1);
      idle(3);
      xfer(8'h3C, 2'd3, 2'd2, 8'hC3, 0, 0, -1);
      idle(2);
      chk("sclk_idle_cpol1", sclk, 1);
      xfer(8'h5A, 2'd1, 2'd1, 8'h96, 0, 0, 5);
      idle(2);
      xfer(8'h01, 2'd0, 2'd0, 8'h00, 1, 0, -1);
      xfer(8'h80, 2'd0, 2'd0, 8'h00, 1, 0, -1);
      idle(2);

      // Abort mid-SHIFT
      data_t = 8'hFF; mode = 2'd0; div_clk = 2'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idle(8);
      rst = 1'b1;
      q.delete();
      #1;
      chk("abort_sclk", sclk, 0);
      chk("abort_mosi", mosi, 0);
      chk("abort_cs_n", cs_n, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_data_r", data_r, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(40);

`ifdef PX_SPI_LSB_FIRST_EN
      xfer(8'h01, 2'd0, 2'd0, 8'h00, 1, 1, -1);
      idle(2);
`endif

      for (int i = 0; i < 24; i++) begin
         lsb = 1'b0;
`ifdef PX_SPI_LSB_FIRST_EN
         lsb = 1'($urandom);
`endif
         xfer(8'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), lsb,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
      idle(5);
      chk("queue_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
